// File: rtl/glyph_fetch_sched.sv
// glyph_fetch_sched
//   Time-multiplexes one single-port synchronous glyph ROM (16x16 digit font)
//   across the nine RGB value digits.  Each accepted line request fetches the
//   nine 16-bit glyph rows in slot order 0..8.  The rows land in a staging
//   register, which is then copied atomically into pix_row.  Optional
//   leading-zero blanking is applied per channel.
//
// Ports
//   clk, clr    : clock, synchronous active-high reset
//   line_start  : one-cycle request to fetch glyph row line_row
//   line_row    : glyph row index 0..15
//   digits      : packed codes {R_h,R_d,R_u,G_h,G_d,G_u,B_h,B_d,B_u}
//   rom_en      : ROM read enable (low for blanked slots and when idle)
//   rom_addr    : {code, row}; zero when not issuing
//   rom_data    : ROM output, valid the cycle after rom_en
//   busy        : fetch in progress (FETCH, DRAIN and COMMIT)
//   line_done   : one-cycle pulse in the cycle pix_row shows the new line
//   pix_row     : committed rows, slot k at [143-16k -: 16]
//   overrun     : sticky flag, set when line_start arrives while busy
module glyph_fetch_sched #(
    parameter int unsigned LZ_BLANK = 1
) (
    input  logic         clk,
    input  logic         clr,
    input  logic         line_start,
    input  logic [3:0]   line_row,
    input  logic [35:0]  digits,
    output logic         rom_en,
    output logic [7:0]   rom_addr,
    input  logic [15:0]  rom_data,
    output logic         busy,
    output logic         line_done,
    output logic [143:0] pix_row,
    output logic         overrun
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_FETCH,
        S_DRAIN,
        S_COMMIT
    } state_t;

    state_t         state_q, state_d;
    logic [3:0]     slot_q, slot_d;
    logic [35:0]    dig_q, dig_d;
    logic [3:0]     row_q, row_d;
    logic           cap_vld_q, cap_vld_d;
    logic [3:0]     cap_slot_q, cap_slot_d;
    logic           cap_zero_q, cap_zero_d;
    logic [143:0]   stage_q, stage_d;
    logic [143:0]   pix_q, pix_d;
    logic           ovr_q, ovr_d;

    logic [8:0]     blank;      // bit k set: slot k is blanked
    logic [3:0]     cur_code;
    logic           cur_blank;

    // Leading-zero blanking mask from the shadowed digits.
    always_comb begin
        blank = '0;
        if (LZ_BLANK != 0) begin
            for (int unsigned c = 0; c < 3; c++) begin
                blank[3*c]   = (dig_q[35-12*c -: 4] == 4'd0);
                blank[3*c+1] = blank[3*c] && (dig_q[31-12*c -: 4] == 4'd0);
            end
        end
    end

    // Code and blank flag of the slot currently being issued.
    always_comb begin
        cur_code  = '0;
        cur_blank = 1'b0;
        for (int unsigned k = 0; k < 9; k++) begin
            if (slot_q == 4'(k)) begin
                cur_code  = dig_q[35-4*k -: 4];
                cur_blank = blank[k];
            end
        end
    end

    always_comb begin
        state_d    = state_q;
        slot_d     = slot_q;
        dig_d      = dig_q;
        row_d      = row_q;
        cap_vld_d  = 1'b0;
        cap_slot_d = cap_slot_q;
        cap_zero_d = 1'b0;
        stage_d    = stage_q;
        pix_d      = pix_q;
        ovr_d      = ovr_q | (line_start && (state_q != S_IDLE));
        rom_en     = 1'b0;
        rom_addr   = '0;
        line_done  = 1'b0;
        busy       = (state_q != S_IDLE);

        // Data issued last cycle is written into its staging slot now.
        // This runs before the state case so DRAIN can commit stage_d,
        // which already contains slot 8, and pix_row is valid in COMMIT.
        if (cap_vld_q) begin
            for (int unsigned k = 0; k < 9; k++) begin
                if (cap_slot_q == 4'(k)) begin
                    stage_d[143-16*k -: 16] = cap_zero_q ? 16'h0000 : rom_data;
                end
            end
        end

        case (state_q)
            S_IDLE: begin
                if (line_start) begin
                    dig_d   = digits;
                    row_d   = line_row;
                    slot_d  = '0;
                    state_d = S_FETCH;
                end
            end
            S_FETCH: begin
                // Blanked slots keep their cycle but leave the ROM idle.
                rom_en     = !cur_blank;
                rom_addr   = cur_blank ? 8'h00 : {cur_code, row_q};
                cap_vld_d  = 1'b1;
                cap_slot_d = slot_q;
                cap_zero_d = cur_blank || (cur_code > 4'd9);
                if (slot_q == 4'd8) begin
                    state_d = S_DRAIN;
                end else begin
                    slot_d = slot_q + 4'd1;
                end
            end
            S_DRAIN: begin
                pix_d   = stage_d;
                state_d = S_COMMIT;
            end
            S_COMMIT: begin
                line_done = 1'b1;
                state_d   = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (clr) begin
            state_q    <= S_IDLE;
            slot_q     <= '0;
            dig_q      <= '0;
            row_q      <= '0;
            cap_vld_q  <= 1'b0;
            cap_slot_q <= '0;
            cap_zero_q <= 1'b0;
            stage_q    <= '0;
            pix_q      <= '0;
            ovr_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            slot_q     <= slot_d;
            dig_q      <= dig_d;
            row_q      <= row_d;
            cap_vld_q  <= cap_vld_d;
            cap_slot_q <= cap_slot_d;
            cap_zero_q <= cap_zero_d;
            stage_q    <= stage_d;
            pix_q      <= pix_d;
            ovr_q      <= ovr_d;
        end
    end

    assign pix_row = pix_q;
    assign overrun = ovr_q;

endmodule

// File: tb/tb_glyph_fetch_sched.sv
// Scoreboard bench for glyph_fetch_sched.  Stimulus pushes expected ROM
// issue addresses and committed rows; a negedge monitor pops and compares
// whenever the DUT drives rom_en or line_done.  A second instance with
// LZ_BLANK = 0 shares the inputs for the no-blanking case.
module tb_glyph_fetch_sched;

    logic         clk = 1'b0;
    logic         clr;
    logic         line_start;
    logic [3:0]   line_row;
    logic [35:0]  digits;

    logic         rom_en, busy, line_done, overrun;
    logic [7:0]   rom_addr;
    logic [15:0]  rom_data = '0;
    logic [143:0] pix_row;

    logic         nb_rom_en, nb_busy, nb_line_done, nb_overrun;
    logic [7:0]   nb_rom_addr;
    logic [15:0]  nb_rom_data = '0;
    logic [143:0] nb_pix_row;

    int errors = 0;
    int checks = 0;
    int nb_en_cnt = 0;

    logic [7:0]   iss_q[$];
    logic [143:0] row_q[$];

    always #5 clk = ~clk;

    glyph_fetch_sched #(.LZ_BLANK(1)) dut (
        .clk(clk), .clr(clr), .line_start(line_start), .line_row(line_row),
        .digits(digits), .rom_en(rom_en), .rom_addr(rom_addr),
        .rom_data(rom_data), .busy(busy), .line_done(line_done),
        .pix_row(pix_row), .overrun(overrun)
    );

    glyph_fetch_sched #(.LZ_BLANK(0)) dut_nb (
        .clk(clk), .clr(clr), .line_start(line_start), .line_row(line_row),
        .digits(digits), .rom_en(nb_rom_en), .rom_addr(nb_rom_addr),
        .rom_data(nb_rom_data), .busy(nb_busy), .line_done(nb_line_done),
        .pix_row(nb_pix_row), .overrun(nb_overrun)
    );

    // Behavioural synchronous ROMs: glyph row = {code, row, 8'hA5}.
    always @(posedge clk) if (rom_en)    rom_data    <= {rom_addr, 8'hA5};
    always @(posedge clk) if (nb_rom_en) nb_rom_data <= {nb_rom_addr, 8'hA5};

    task automatic chk(input string name, input logic [143:0] act, input logic [143:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Reference model: expected issues and committed row for LZ_BLANK = 1.
    task automatic push_line(input logic [35:0] d, input logic [3:0] r);
        logic [143:0] row;
        logic [3:0]   code;
        logic         hz, bl;
        row = '0;
        hz  = 1'b0;
        for (int k = 0; k < 9; k++) begin
            code = d[35-4*k -: 4];
            case (k % 3)
                0:       begin bl = (code == 4'd0); hz = bl; end
                1:       bl = hz && (code == 4'd0);
                default: bl = 1'b0;
            endcase
            if (!bl) iss_q.push_back({code, r});
            row[143-16*k -: 16] = (bl || code > 4'd9) ? 16'h0000 : {code, r, 8'hA5};
        end
        row_q.push_back(row);
    endtask

    // Issues a line at the current negedge (cycle T) and waits for
    // line_done, which must arrive 11 cycles later.  Returns at T+11.
    task automatic do_line(input logic [35:0] d, input logic [3:0] r);
        int n;
        line_start = 1'b1;
        digits     = d;
        line_row   = r;
        push_line(d, r);
        @(negedge clk);
        line_start = 1'b0;
        n = 1;
        chk("busy_after_accept", 144'(busy), 144'(1));
        while (!line_done && n < 30) begin
            @(negedge clk);
            n++;
        end
        chk("line_done_latency", 144'(n), 144'(11));
        chk("busy_in_commit", 144'(busy), 144'(1));
    endtask

    // Monitor / scoreboard.
    always @(negedge clk) begin
        if (nb_rom_en) nb_en_cnt++;
        if (rom_en) begin
            if (iss_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL rom_issue: unexpected rom_en with addr %h", rom_addr);
            end else begin
                chk("rom_addr", 144'(rom_addr), 144'(iss_q.pop_front()));
            end
        end
        if (line_done) begin
            if (row_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL line_done: unexpected pulse, pix_row %h", pix_row);
            end else begin
                chk("pix_row", pix_row, row_q.pop_front());
            end
        end
    end

    initial begin
        int c0;
        int dones;
        clr        = 1'b1;
        line_start = 1'b0;
        line_row   = '0;
        digits     = '0;
        repeat (3) @(negedge clk);
        chk("reset_outputs", {pix_row, rom_en, rom_addr, busy, line_done, overrun}, '0);
        clr = 1'b0;
        @(negedge clk);

        // Mixed digits with a blanked G hundreds.
        do_line(36'h123045999, 4'd7);
        chk("row_t1_hand", pix_row,
            144'h17A5_27A5_37A5_0000_47A5_57A5_97A5_97A5_97A5);
        @(negedge clk);
        chk("idle_after_commit", 144'({busy, rom_en, line_done}), 144'(0));

        // R = 000: blank h and d, units still shows glyph 0.
        c0 = nb_en_cnt;
        do_line(36'h000123456, 4'd3);
        chk("row_t2_hand", pix_row,
            144'h0000_0000_03A5_13A5_23A5_33A5_43A5_53A5_63A5);
        chk("nb_rom_en_count", 144'(nb_en_cnt - c0), 144'(9));
        chk("nb_row", nb_pix_row,
            144'h03A5_03A5_03A5_13A5_23A5_33A5_43A5_53A5_63A5);
        @(negedge clk);

        // Out-of-range code in slot 5 is fetched but committed as zero.
        do_line(36'h12345C678, 4'd2);
        chk("row_t3_hand", pix_row,
            144'h12A5_22A5_32A5_42A5_52A5_0000_62A5_72A5_82A5);
        @(negedge clk);

        // line_start at T+4 and T+11 ignored; overrun sticks.
        chk("overrun_clear", 144'(overrun), 144'(0));
        line_start = 1'b1;
        digits     = 36'h111222333;
        line_row   = 4'd1;
        push_line(36'h111222333, 4'd1);
        dones = 0;
        for (int n = 1; n <= 11; n++) begin
            @(negedge clk);
            if (line_done) dones++;
            case (n)
                1:  line_start = 1'b0;
                4:  begin line_start = 1'b1; digits = 36'h999999999; line_row = 4'd9; end
                5:  line_start = 1'b0;
                11: begin
                        chk("ovr_line_done_t11", 144'(line_done), 144'(1));
                        line_start = 1'b1;
                    end
                default: ;
            endcase
        end
        chk("ovr_single_done", 144'(dones), 144'(1));
        @(negedge clk);
        chk("overrun_set", 144'(overrun), 144'(1));
        do_line(36'h444555666, 4'd4);
        chk("overrun_sticky", 144'(overrun), 144'(1));
        @(negedge clk);

        // clr mid-fetch at T+5: slots 0..4 issue, then abort.
        line_start = 1'b1;
        digits     = 36'h123456789;
        line_row   = 4'd5;
        iss_q.push_back(8'h15);
        iss_q.push_back(8'h25);
        iss_q.push_back(8'h35);
        iss_q.push_back(8'h45);
        iss_q.push_back(8'h55);
        for (int n = 1; n <= 5; n++) begin
            @(negedge clk);
            if (n == 1) line_start = 1'b0;
            if (n == 5) clr = 1'b1;
        end
        @(negedge clk);
        clr = 1'b0;
        chk("clr_state", {pix_row, busy, rom_en, overrun}, '0);
        repeat (15) @(negedge clk);
        chk("clr_issue_queue", 144'(iss_q.size()), 144'(0));
        do_line(36'h987654321, 4'd8);
        @(negedge clk);

        // Back-to-back lines every 12 cycles, rows 0..15.
        for (int r = 0; r < 16; r++) begin
            do_line(36'h007080123, 4'(r));
            @(negedge clk);
        end
        chk("b2b_overrun", 144'(overrun), 144'(0));
        chk("b2b_row_queue", 144'(row_q.size()), 144'(0));
        chk("b2b_issue_queue", 144'(iss_q.size()), 144'(0));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
